// File: rtl/universal_shift_reg_if.sv
// Command/status bundle for universal_shift_reg.
// The controller drives master; the shift register is the slave.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(WIDTH) + 1;

    logic             start;
    logic [2:0]       op;
    logic [AW-1:0]    amount;
    logic [WIDTH-1:0] data_in;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             done;
    logic             carry_out;
    logic [WIDTH-1:0] Q;

    modport master (
        output start, op, amount, data_in, abort,
        input  ready, busy, done, carry_out, Q
    );

    modport slave (
        input  start, op, amount, data_in, abort,
        output ready, busy, done, carry_out, Q
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift/rotate register with start/ready/done handshake.
// Define UNIV_SHIFT_BARREL_EN for single-edge barrel shifts instead of serial stepping.
module universal_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    universal_shift_reg_if.slave  bus
);
    localparam int AW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ROTR  = 3'b001;
    localparam logic [2:0] OP_ROTL  = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_ASR   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic             is_shift;

    // Returns {carry, next value} for one single-bit step.
    function automatic logic [WIDTH:0] step1(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] v
    );
        logic [WIDTH:0] r;
        r = {1'b0, v};
        case (o)
            OP_ROTR: r = {v[0], v[0], v[WIDTH-1:1]};
            OP_ROTL: r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OP_SHR:  r = {v[0], 1'b0, v[WIDTH-1:1]};
            OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    assign is_shift = bus.op inside {OP_ROTR, OP_ROTL, OP_SHR, OP_SHL, OP_ASR};

`ifdef UNIV_SHIFT_BARREL_EN
    logic [2*WIDTH-1:0] wide;
    logic [AW-1:0]      rot_n;
    logic [WIDTH:0]     bar;

    // Carry is the last bit to leave the register, read from the double-width result.
    always_comb begin
        wide  = '0;
        bar   = {carry_q, q_q};
        rot_n = bus.amount % AW'(WIDTH);
        case (bus.op)
            OP_ROTR: begin
                wide = {q_q, q_q} >> rot_n;
                bar  = {wide[WIDTH-1], wide[WIDTH-1:0]};
            end
            OP_ROTL: begin
                wide = {q_q, q_q} << rot_n;
                bar  = {wide[WIDTH], wide[2*WIDTH-1:WIDTH]};
            end
            OP_SHR: begin
                wide = {q_q, {WIDTH{1'b0}}} >> bus.amount;
                bar  = {wide[WIDTH-1], wide[2*WIDTH-1:WIDTH]};
            end
            OP_SHL: begin
                wide = {{WIDTH{1'b0}}, q_q} << bus.amount;
                bar  = {wide[WIDTH], wide[WIDTH-1:0]};
            end
            OP_ASR: begin
                wide = $signed({q_q, {WIDTH{1'b0}}}) >>> bus.amount;
                bar  = {wide[WIDTH-1], wide[2*WIDTH-1:WIDTH]};
            end
            default: ;
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!is_shift) begin
                        done_d = 1'b1;
                        if (bus.op == OP_LOAD) begin
                            q_d = bus.data_in;
                        end else if (bus.op == OP_CLEAR) begin
                            q_d = '0;
                        end
                    end else if (bus.amount == '0) begin
                        done_d = 1'b1;
                    end else begin
`ifdef UNIV_SHIFT_BARREL_EN
                        {carry_d, q_d} = bar;
                        done_d = 1'b1;
`else
                        {carry_d, q_d} = step1(bus.op, q_q);
                        op_d = bus.op;
                        if (bus.amount == AW'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                            rem_d   = bus.amount - AW'(1);
                        end
`endif
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    {carry_d, q_d} = step1(op_q, q_q);
                    rem_d = rem_q - AW'(1);
                    if (rem_q == AW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            q_q     <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            op_q    <= OP_LOAD;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus.carry_out = carry_q;
    assign bus.done      = done_q;
    assign bus.ready     = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift/rotate register that supersedes the fixed 4-bit rotate unit. It holds a WIDTH-bit value and executes one command at a time: load, clear, rotate left/right, logical shift left/right, or arithmetic shift right, by a runtime amount, using a start/ready/done handshake. It sits between a datapath controller and any consumer of Q, such as display or ALU operand logic.

## Interface
- WIDTH, 8: register width in bits, ≥2.
- AW, $clog2(WIDTH)+1: width of `amount`; derived, not to be overridden.
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  command request; sampled only while ready=1.
- op  in  3  000 LOAD, 001 ROTR, 010 ROTL, 011 SHR logical, 100 SHL, 101 ASR, 110 CLEAR, 111 NOP.
- amount  in  AW  number of single-bit steps, 0..2^AW-1.
- data_in  in  WIDTH  value for LOAD.
- abort  in  1  synchronous cancel of a running command.
- ready  out  1  block idle and accepting start.
- busy  out  1  multi-cycle command in progress; always equals ~ready.
- done  out  1  one-cycle pulse after a command completes.
- carry_out  out  1  bit shifted or wrapped out on the most recent step.
- Q  out  WIDTH  register contents.

## Operation
- States: IDLE, RUN. Reset state is IDLE. While resetn=0: Q=0, carry_out=0, done=0, ready=1, busy=0, and the step counter is 0.
- Start is accepted at a rising edge with start=1 and state IDLE (edge k). Start in RUN is ignored; no queueing.
- LOAD: Q<=data_in at edge k. CLEAR: Q<=0 at edge k. NOP: Q is unchanged. carry_out is unchanged for all three. `amount` is ignored. State stays IDLE.
- Shift/rotate ops with amount=0: Q and carry_out are unchanged. State stays IDLE. done still pulses.
- Single step definitions:
  - ROTR: Q<={Q[0],Q[W-1:1]}; carry=Q[0].
  - ROTL: Q<={Q[W-2:0],Q[W-1]}; carry=Q[W-1].
  - SHR: fill 0; carry=Q[0].
  - SHL: fill 0; carry=Q[W-1].
  - ASR: fill Q[W-1]; carry=Q[0].
- Amount n≥1: the first step executes at edge k, and op is latched.
  - n=1: stay IDLE.
  - n>1: go to RUN with remaining=n-1.
  - Each RUN edge executes one step and decrements remaining. The edge where remaining goes 1→0 returns the block to IDLE.
- Amounts ≥ WIDTH are stepped literally. The result is the same as repeated single steps: rotates wrap modulo WIDTH; SHR/SHL yield 0 with carry 0 once n>WIDTH; ASR yields all sign bits.
- abort=1 in RUN at an edge: no step executes, Q keeps its partial result, state goes to IDLE, and no done pulse is produced. abort in IDLE has no effect. abort has priority over the step.
- Async reset mid-RUN: immediate return to reset values; the command is lost.

## Timing
- done is registered. It is high for exactly the one cycle following the edge that completes a command (edge k for single-edge commands, edge k+n-1 otherwise). ready is already 1 in that same cycle.
- Back-to-back: a new start may be accepted on the edge that ends the done cycle. The throughput for single-edge commands is one per cycle.
- Shift by n≥1 latency: the final Q is visible n edges after acceptance (edge k+n-1). Intermediate Q values are visible each cycle.
- carry_out updates only on edges that execute a step.

## Configuration
- UNIV_SHIFT_BARREL_EN defined: every shift/rotate completes at edge k with one combinational barrel stage. RUN is never entered, busy stays 0, and done pulses in the cycle after edge k.
  - Q and carry_out must be bit-identical to the serial result for every op and amount, including amounts ≥ WIDTH.
  - abort has no observable effect.
- Undefined: serial one-step-per-cycle behaviour as described above.

## Test plan
- Reset: assert resetn=0 mid-RUN of ROTR by 5 -> Q=0x00, carry_out=0, ready=1, done=0 immediately, without waiting for a clock edge.
- LOAD 0xB4, then ROTR by 3 -> Q sequence 0x5A, 0x2D, 0x96; carry_out 0,0,1; done one cycle after third step (serial). With macro: 0x96 after one edge.
- LOAD 0x81, then ASR by 9 -> Q=0xFF, carry_out=1. SHR by 9 from 0x81 -> Q=0x00, carry_out=0. Both hold in both configurations.
- ROTL by 0 from 0x3C -> Q=0x3C, carry unchanged, done pulse next cycle, ready stays 1.
- SHL by 6 from 0x0F, abort asserted on the third RUN edge -> Q=0x78, no done pulse, ready=1. A start issued while busy earlier in the same run is ignored.
- Back-to-back LOAD 0x11, CLEAR, LOAD 0x22 on consecutive edges -> Q 0x11, 0x00, 0x22, with done high for three consecutive cycles.
